// File: rtl/cfi_flash_tristate_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cfi_flash_tristate_controller
//
// Avalon-MM slave that turns single-beat read/write commands into timed CFI
// flash pin cycles (chip select, output enable, write enable, address, split
// data). The pin-side outputs feed a tristate conduit bridge that merges
// tcm_data_out / tcm_data_outen / tcm_data_in onto the shared inout data bus.
//
// Access sequence: IDLE -> SETUP -> STROBE -> HOLD -> TURN -> IDLE.
// TURN is skipped when TURNAROUND_CYCLES is 0. A single 8-bit down-counter
// is loaded with (state length - 1) on every state entry.
//
// Handshake: a command is accepted on a rising edge where avs_waitrequest is
// 0 and avs_read or avs_write is 1. While avs_waitrequest is 1, requests are
// ignored and the master must hold them. avs_readdatavalid is a one-cycle
// pulse qualifying avs_readdata. A read wins over a simultaneous write.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   avs_*                 Avalon-MM slave (address, read, write, writedata,
//                         waitrequest, readdata, readdatavalid)
//   tcm_address           flash address
//   tcm_chipselect_n      flash chip enable, active low
//   tcm_read_n            flash output enable, active low
//   tcm_write_n           flash write enable, active low
//   tcm_data_out          data driven towards the flash
//   tcm_data_outen        data bus drive enable, active high
//   tcm_data_in           data returned from the flash
//
// Every output comes straight from a flop; pin values are computed from the
// next state so that they change on the same edge as the state register.
// -----------------------------------------------------------------------------
module cfi_flash_tristate_controller #(
    parameter int ADDR_W            = 22,
    parameter int DATA_W            = 8,
    parameter int SETUP_CYCLES      = 2,
    parameter int WAIT_CYCLES       = 8,
    parameter int HOLD_CYCLES       = 2,
    parameter int TURNAROUND_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic              avs_waitrequest,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_readdatavalid,
    output logic [ADDR_W-1:0] tcm_address,
    output logic              tcm_chipselect_n,
    output logic              tcm_read_n,
    output logic              tcm_write_n,
    output logic [DATA_W-1:0] tcm_data_out,
    output logic              tcm_data_outen,
    input  logic [DATA_W-1:0] tcm_data_in
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_TURN   = 3'd4
    } state_t;

    // Counter reload values. TURN_LD wraps to 8'hFF when TURNAROUND_CYCLES
    // is 0, but TURN is never entered in that configuration.
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] WAIT_LD  = 8'(WAIT_CYCLES - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] TURN_LD  = 8'(TURNAROUND_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       op_read, op_read_nxt;   // 1 = current access is a read
    logic       accept;
    logic       active_nxt;             // chip selected in the next cycle
    logic       strobe_nxt;             // strobe low in the next cycle
    logic       capture;                // leaving STROBE on a read

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        op_read_nxt = op_read;
        accept      = 1'b0;

        case (state)
            ST_IDLE: begin
                // waitrequest is still 1 in the first cycle after reset,
                // so it gates acceptance here as well.
                if (!avs_waitrequest && (avs_read || avs_write)) begin
                    accept      = 1'b1;
                    state_nxt   = ST_SETUP;
                    cnt_nxt     = SETUP_LD;
                    op_read_nxt = avs_read;
                end
            end
            ST_SETUP: begin
                if (cnt == 8'd0) begin
                    state_nxt = ST_STROBE;
                    cnt_nxt   = WAIT_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_STROBE: begin
                if (cnt == 8'd0) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = HOLD_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_HOLD: begin
                if (cnt == 8'd0) begin
                    if (TURNAROUND_CYCLES == 0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_TURN;
                        cnt_nxt   = TURN_LD;
                    end
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_TURN: begin
                if (cnt == 8'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        active_nxt = (state_nxt == ST_SETUP) || (state_nxt == ST_STROBE) ||
                     (state_nxt == ST_HOLD);
        strobe_nxt = (state_nxt == ST_STROBE);
        capture    = (state == ST_STROBE) && (state_nxt == ST_HOLD) && op_read;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_IDLE;
            cnt               <= 8'd0;
            op_read           <= 1'b0;
            avs_waitrequest   <= 1'b1;
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
            tcm_address       <= '0;
            tcm_chipselect_n  <= 1'b1;
            tcm_read_n        <= 1'b1;
            tcm_write_n       <= 1'b1;
            tcm_data_out      <= '0;
            tcm_data_outen    <= 1'b0;
        end else begin
            state             <= state_nxt;
            cnt               <= cnt_nxt;
            op_read           <= op_read_nxt;
            avs_waitrequest   <= (state_nxt != ST_IDLE);
            avs_readdatavalid <= capture;
            if (capture) begin
                avs_readdata <= tcm_data_in;
            end
            if (accept) begin
                tcm_address <= avs_address;
            end
            // Write data is only latched for a real write; a read that won
            // over a simultaneous write leaves the data register alone.
            if (accept && !avs_read) begin
                tcm_data_out <= avs_writedata;
            end
            tcm_chipselect_n  <= !active_nxt;
            tcm_read_n        <= !(strobe_nxt && op_read_nxt);
            tcm_write_n       <= !(strobe_nxt && !op_read_nxt);
            tcm_data_outen    <= active_nxt && !op_read_nxt;
        end
    end

endmodule
